// File: rtl/mips_pkg.sv
// Constants shared by the fetch stage and its IF/ID register.
package mips_pkg;
  localparam int          WORD_W           = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures fetched word, pc and pc+4 one cycle after the read.
// Holds while load_en is low; flush drops the valid bit and forces a NOP over any stall.
module if_id_register
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              flush,
  input  logic [WORD_W-1:0] fetch_instr,
  input  logic [WORD_W-1:0] fetch_pc,
  input  logic [WORD_W-1:0] fetch_pc_plus4,
  output logic              valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (flush) begin
      // pc fields are left as-is; valid=0 already marks them meaningless
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load_en) begin
      valid    <= 1'b1;
      instr    <= fetch_instr;
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// PC generation and fetch: imem_addr = pc, word lands in IF/ID next cycle (zero bubble).
// Fetch stalls only while IF/ID is valid and decode is not ready; redirects always win.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 256,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  output logic             misalign_err,
  output logic             pc_oob,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        load_en;
  logic        transfer;

  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_INC;
  assign transfer  = if_valid & id_ready;
  assign load_en   = ~if_valid | id_ready;
  assign pc_oob    = pc[31:2] >= WORD_LIMIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      misalign_err <= redirect_valid & (|redirect_target[1:0]);
      // a transfer in the same cycle as a redirect was still consumed by decode
      if (transfer) fetch_count <= fetch_count + CNT_W'(1);
      if (redirect_valid)  pc <= {redirect_target[31:2], 2'b00};
      else if (load_en)    pc <= pc_plus4;
    end
  end

  if_id_register u_if_id (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .flush         (redirect_valid),
    .fetch_instr   (imem_instr),
    .fetch_pc      (pc),
    .fetch_pc_plus4(pc_plus4),
    .valid         (if_valid),
    .instr         (if_instr),
    .pc            (if_pc),
    .pc_plus4      (if_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized + directed bench for instruction_fetch against a cycle-level behavioural model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;
  logic        pc_oob;
  logic [15:0] fetch_count;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(256), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .id_ready(id_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .misalign_err(misalign_err), .pc_oob(pc_oob),
    .fetch_count(fetch_count)
  );

  // memory image; out-of-range addresses return a recognisable address-derived pattern
  logic [31:0] mem [0:255];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd1024) return mem[a[9:2]];
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // reference model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_mis;
  logic [15:0] m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    check("if_instr", if_instr, m_instr);
    check("if_pc", if_pc, m_ipc);
    check("if_pc_plus4", if_pc_plus4, m_ipc4);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
    check("pc_oob", {31'b0, pc_oob}, {31'b0, (m_pc / 4) >= 256});
    check("fetch_count", {16'b0, fetch_count}, {16'b0, m_cnt});
  endtask

  // one clock: drive at negedge, model reacts at posedge, compare at next negedge
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rt, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_target = rt; id_ready = rdy;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_mis = 0; m_cnt = 0;
    end else begin
      m_mis = rv && (rt % 4 != 0);
      if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
      if (rv) begin
        m_pc = rt - (rt % 4); m_valid = 0; m_instr = 0;
      end else if (!m_valid || rdy) begin
        m_valid = 1; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mem_word(m_pc);
        m_pc = m_pc + 4;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C22_0004; mem[1] = 32'hAC22_0004;
    mem[2] = 32'h2022_0004; mem[3] = 32'h2422_0004;
    reset = 1; redirect_valid = 0; redirect_target = 0; id_ready = 0;
    m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_mis = 0; m_cnt = 0;
    @(negedge clk);

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);

    // straight-line fetch
    cycle(0, 0, 0, 1);
    check("seq_if_pc0", if_pc, 32'h0);
    cycle(0, 0, 0, 1);
    check("seq_instr1", if_instr, 32'hAC22_0004);
    check("seq_addr8", imem_addr, 32'h8);

    // stall three cycles holding pc 4
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    check("stall_instr", if_instr, 32'hAC22_0004);
    check("stall_addr", imem_addr, 32'h8);
    cycle(0, 0, 0, 1);
    check("release_pc", if_pc, 32'h8);
    check("release_instr", if_instr, 32'h2022_0004);
    check("release_cnt", {16'b0, fetch_count}, 32'd2);
    cycle(0, 0, 0, 1);
    check("cnt3", {16'b0, fetch_count}, 32'd3);

    // redirect while stalled
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h88, 0);
    check("redir_flush", {31'b0, if_valid}, 32'd0);
    check("redir_addr", imem_addr, 32'h88);
    cycle(0, 0, 0, 1);
    check("redir_if_pc", if_pc, 32'h88);
    check("redir_instr", if_instr, mem[34]);

    // misaligned redirect: one-cycle pulse
    cycle(0, 1, 32'h8B, 1);
    check("mis_addr", imem_addr, 32'h88);
    check("mis_pulse", {31'b0, misalign_err}, 32'd1);
    cycle(0, 0, 0, 1);
    check("mis_clear", {31'b0, misalign_err}, 32'd0);

    // range boundary and wrap
    cycle(0, 1, 32'h3FC, 1);
    check("oob_edge", {31'b0, pc_oob}, 32'd0);
    cycle(0, 0, 0, 1);
    check("oob_past", {31'b0, pc_oob}, 32'd1);
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_plus4", if_pc_plus4, 32'h0);

    // reset mid-stream while valid and stalled, with a redirect pending
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h40, 0);
    check("mrst_valid", {31'b0, if_valid}, 32'd0);
    check("mrst_cnt", {16'b0, fetch_count}, 32'd0);
    cycle(0, 0, 0, 1);
    check("mrst_resume", if_pc, 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic rv, rst;
      rst = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        1:       tgt = 32'h3F0 + $urandom_range(0, 31);
        default: tgt = $urandom_range(0, 32'h4FF);
      endcase
      cycle(rst, rv, tgt, $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
